// File: rtl/rv32i_types.sv
// Shared RV32I types used by the memory-access stage: funct3 encodings and the LSU state.
package rv32i_types;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a cache word and sign- or zero-extends it.
module load_align
    import rv32i_types::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] result_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v   = 8'(rdata >> {offset, 3'b000});
        half_v   = offset[1] ? rdata[31:16] : rdata[15:0];
        result_c = rdata;
        case (funct3)
            lb:      result_c = {{24{byte_v[7]}}, byte_v};
            lh:      result_c = {{16{half_v[15]}}, half_v};
            lbu:     result_c = {24'd0, byte_v};
            lhu:     result_c = {16'd0, half_v};
            default: result_c = rdata;
        endcase
    end

endmodule

// File: rtl/stage_memory_access.sv
// MEM pipeline stage: data-cache handshake, store lane masks, load alignment, pipeline stall.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned accesses into a flagged no-op.
module stage_memory_access
    import rv32i_types::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] dmem_address,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [3:0]      dmem_wmask,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_resp,
    output logic [XLEN-1:0] mem_rdata_o,
    output logic            stall_o,
    output logic            misalign_o
);

    lsu_state_t      state;
    logic            op_ok;
    logic            mem_op;
    logic            trap_c;
    logic            issue;
    logic [1:0]      offset;
    logic [XLEN-1:0] align_result;
    logic [XLEN-1:0] capture;

    assign offset = alu_out_i[1:0];

    load_align u_load_align (
        .rdata    (dmem_rdata),
        .funct3   (funct3_i),
        .offset   (offset),
        .result_c (align_result)
    );

    // Unknown funct3 for the operation kind means the instruction is not a memory op.
    always_comb begin
        op_ok = 1'b0;
        if (mem_read_i) begin
            case (funct3_i)
                lb, lh, lw, lbu, lhu: op_ok = 1'b1;
                default:              op_ok = 1'b0;
            endcase
        end else if (mem_write_i) begin
            case (funct3_i)
                sb, sh, sw: op_ok = 1'b1;
                default:    op_ok = 1'b0;
            endcase
        end
    end

    assign mem_op  = valid_i & (mem_read_i | mem_write_i) & op_ok;
    assign capture = mem_read_i ? align_result : '0;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    assign trap_c = mem_op & (((funct3_i[1:0] == 2'b01) & offset[0]) |
                              ((funct3_i[1:0] == 2'b10) & (offset != 2'b00)));

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (state == IDLE) begin
            misalign_q <= trap_c;
        end else if (state == DONE && advance_i) begin
            misalign_q <= 1'b0;
        end
    end

    assign misalign_o = ((state == IDLE) & trap_c) | ((state == DONE) & misalign_q);
`else
    assign trap_c     = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign issue = mem_op & ~trap_c & (state != DONE);

    // Request is a pure function of the frozen EX/MEM inputs, so it stays stable through WAIT.
    always_comb begin
        dmem_address = '0;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_wmask   = 4'b0000;
        dmem_wdata   = '0;
        stall_o      = (state == WAIT) | ((state == IDLE) & mem_op);
        if (issue) begin
            dmem_address = {alu_out_i[31:2], 2'b00};
            dmem_read    = mem_read_i;
            dmem_write   = ~mem_read_i;
            if (~mem_read_i) begin
                case (funct3_i)
                    sb: begin
                        dmem_wmask = 4'(4'b0001 << offset);
                        dmem_wdata = rs2_i << {offset, 3'b000};
                    end
                    sh: begin
                        dmem_wmask = 4'(4'b0011 << offset);
                        dmem_wdata = rs2_i << {offset, 3'b000};
                    end
                    default: begin
                        dmem_wmask = 4'b1111;
                        dmem_wdata = rs2_i;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_c) begin
                        state       <= DONE;
                        mem_rdata_o <= '0;
                    end else if (mem_op) begin
                        if (dmem_resp) begin
                            state       <= DONE;
                            mem_rdata_o <= capture;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_resp) begin
                        state       <= DONE;
                        mem_rdata_o <= capture;
                    end
                end
                DONE: begin
                    if (advance_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
